// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/HALT sequencer feeding a small circular fetch queue.
// Optional fetch counter port fetch_cnt_o is built only when IFC_FETCH_CNT_EN is defined.
module instr_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_WORDS = 65,
   parameter int          QDEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_pc_o,
   output logic        halted_o
`ifdef IFC_FETCH_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o
`endif
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);
   localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        buf_pc_q    [QDEPTH];
   logic [31:0]        buf_instr_q [QDEPTH];

   logic        pc_in_range;
   logic [31:0] redir_tgt;
   logic        tgt_in_range;
   logic        push;
   logic        pop;
   logic        valid;

   assign redir_tgt    = redirect_pc_i & 32'hFFFF_FFFC;
   assign pc_in_range  = {1'b0, pc_q} < PC_LIMIT;
   assign tgt_in_range = {1'b0, redir_tgt} < PC_LIMIT;

   // A redirect hides the head so decode never consumes a stale-path entry.
   assign valid = (count_q != '0) && !redirect_i;
   assign pop   = valid && out_ready_i;
   assign push  = (state_q == ST_FETCH) && pc_in_range && !redirect_i &&
                  ((count_q < QDEPTH_C) || pop);

   assign imem_addr_o = pc_q;
   assign out_valid_o = valid;
   assign out_pc_o    = buf_pc_q[rd_ptr_q];
   assign out_instr_o = buf_instr_q[rd_ptr_q];
   assign halted_o    = (state_q == ST_HALT);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (en_i) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (!en_i)                          state_d = ST_IDLE;
            else if (!redirect_i && !pc_in_range) state_d = ST_HALT;
         end
         ST_HALT: begin
            if (redirect_i && tgt_in_range) state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_i) begin
         // Flush by collapsing the read pointer onto the write pointer.
         pc_d     = redir_tgt;
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            pc_d     = pc_q + 32'd4;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_pc_q[wr_ptr_q]    <= pc_q;
         buf_instr_q[wr_ptr_q] <= imem_instr_i;
      end
   end

`ifdef IFC_FETCH_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (push) fetch_cnt_d = fetch_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) fetch_cnt_q <= '0;
      else       fetch_cnt_q <= fetch_cnt_d;
   end

   assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a queue-based behavioural model.
module tb_instr_fetch_ctrl;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          MEM_WORDS = 65;
   localparam int          QDEPTH    = 4;
   localparam int          LIM       = MEM_WORDS * 4;
   localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0, en_i = 1'b0, redirect_i = 1'b0, out_ready_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic [31:0] imem_addr_o, imem_instr_i, out_instr_o, out_pc_o;
   logic        out_valid_o, halted_o;
`ifdef IFC_FETCH_CNT_EN
   logic [31:0] fetch_cnt_o;
`endif

   instr_fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS), .QDEPTH(QDEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
      .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .halted_o(halted_o)
`ifdef IFC_FETCH_CNT_EN
      , .fetch_cnt_o(fetch_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] tb_mem [MEM_WORDS];
   always_comb begin
      int idx;
      idx = int'(imem_addr_o >> 2);
      imem_instr_i = 32'hDEAD_BEEF;
      if (imem_addr_o < 32'(LIM)) imem_instr_i = tb_mem[idx];
   end

   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t        mq[$];
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   bit          model_ok = 0;

   int n_checks = 0, n_pass = 0;
   logic        obs_valid, obs_halted;
   logic [31:0] obs_pc, obs_instr, obs_addr, obs_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // One clock cycle: drive, compare against model, advance model, cross the edge.
   task automatic step(input logic en, input logic rd, input logic rdy,
                       input logic [31:0] rpc, input logic rst);
      bit e_valid, pop, fetch;
      int nm;
      logic [31:0] tgt;
      en_i = en; redirect_i = rd; out_ready_i = rdy; redirect_pc_i = rpc; rst_i = rst;
      #1;
      obs_valid = out_valid_o; obs_halted = halted_o; obs_pc = out_pc_o;
      obs_instr = out_instr_o; obs_addr = imem_addr_o; obs_cnt = '0;
`ifdef IFC_FETCH_CNT_EN
      obs_cnt = fetch_cnt_o;
`endif
      e_valid = (mq.size() != 0) && !rd;
      if (model_ok) begin
         check_eq("valid", 32'(obs_valid), 32'(e_valid));
         check_eq("addr", obs_addr, m_pc);
         check_eq("halted", 32'(obs_halted), 32'(m_mode == M_HALT));
         if (e_valid && obs_valid) begin
            check_eq("head_pc", obs_pc, mq[0].pc);
            check_eq("head_instr", obs_instr, mq[0].instr);
         end
`ifdef IFC_FETCH_CNT_EN
         check_eq("fetch_cnt", obs_cnt, m_cnt);
`endif
      end
      pop   = e_valid && rdy;
      fetch = (m_mode == M_FETCH) && (m_pc < 32'(LIM)) && !rd && ((mq.size() < QDEPTH) || pop);
      tgt   = rpc & 32'hFFFF_FFFC;
      if (rst) begin
         mq.delete(); m_pc = RESET_PC; m_mode = M_IDLE; m_cnt = '0; model_ok = 1;
      end else begin
         nm = m_mode;
         if (m_mode == M_IDLE && en) nm = M_FETCH;
         else if (m_mode == M_FETCH && !en) nm = M_IDLE;
         else if (m_mode == M_FETCH && !rd && m_pc >= 32'(LIM)) nm = M_HALT;
         else if (m_mode == M_HALT && rd && tgt < 32'(LIM)) nm = M_FETCH;
         if (rd) begin
            mq.delete(); m_pc = tgt;
         end else begin
            if (pop) void'(mq.pop_front());
            if (fetch) begin
               mq.push_back('{pc: m_pc, instr: tb_mem[int'(m_pc >> 2)]});
               m_pc  = m_pc + 32'd4;
               m_cnt = m_cnt + 32'd1;
            end
         end
         m_mode = nm;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      int cyc;
      logic [31:0] last_pc;
      for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] = $urandom;
      tb_mem[0] = 32'h11; tb_mem[1] = 32'h22; tb_mem[2] = 32'h33; tb_mem[3] = 32'h44;
      @(negedge clk);

      // Streaming from reset: head appears two cycles after enable, one per cycle.
      do_reset();
      check_eq("rst_valid", 32'(out_valid_o), 32'd0);
      check_eq("rst_addr", imem_addr_o, RESET_PC);
      check_eq("rst_halted", 32'(halted_o), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b1, '0, 1'b0);
         if (i < 2) check_eq("s1_early_valid", 32'(obs_valid), 32'd0);
         else begin
            check_eq("s1_valid", 32'(obs_valid), 32'd1);
            check_eq("s1_pc", obs_pc, 32'(4 * (i - 2)));
            check_eq("s1_instr", obs_instr, 32'(8'h11 * (i - 1)));
         end
      end

      // Fill with decode stalled, then release with simultaneous push/pop.
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      check_eq("s2_full_addr", obs_addr, 32'h10);
      check_eq("s2_full_head", obs_pc, 32'h0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b1, '0, 1'b0);
         check_eq("s2_seq_pc", obs_pc, 32'(4 * i));
      end

      // Redirect with three queued entries and decode ready.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h23, 1'b0);
      check_eq("s3_redir_valid", 32'(obs_valid), 32'd0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      check_eq("s3_flushed", 32'(obs_valid), 32'd0);
      check_eq("s3_addr", obs_addr, 32'h20);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      check_eq("s3_head_pc", obs_pc, 32'h20);

      // Run off the end of memory, drain, then redirect back to 0.
      do_reset();
      cyc = 0; last_pc = '0;
      while (!obs_halted && cyc < 400) begin
         step(1'b1, 1'b0, 1'b1, '0, 1'b0);
         if (obs_valid) last_pc = obs_pc;
         cyc++;
      end
      check_eq("s4_halt_reached", 32'(cyc < 400), 32'd1);
      check_eq("s4_halt_addr", obs_addr, 32'h104);
      check_eq("s4_last_pc", last_pc, 32'h100);
      step(1'b1, 1'b0, 1'b1, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, '0, 1'b0);
      check_eq("s4_drained", 32'(obs_valid), 32'd0);
      check_eq("s4_still_halted", 32'(obs_halted), 32'd1);
      step(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      check_eq("s4_resumed", 32'(obs_halted), 32'd0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      check_eq("s4_resume_pc", obs_pc, 32'h0);

      // Reset mid-stream with a full queue and a concurrent redirect.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 32'h40, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      check_eq("s5_valid", 32'(obs_valid), 32'd0);
      check_eq("s5_addr", obs_addr, RESET_PC);
      check_eq("s5_halted", 32'(obs_halted), 32'd0);
`ifdef IFC_FETCH_CNT_EN
      check_eq("s5_cnt_clr", obs_cnt, 32'd0);
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b1, '0, 1'b0);
      step(1'b0, 1'b0, 1'b1, '0, 1'b0);
      check_eq("s5_cnt10", obs_cnt, 32'd10);
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         logic en, rd, rdy, rst;
         logic [31:0] rpc;
         en  = ($urandom_range(0, 9) != 0);
         rd  = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 249) == 0);
         rpc = 32'($urandom_range(0, LIM + 15));
         step(en, rd, rdy, rpc, rst);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
